// File: rtl/fib_seq_ctrl_pkg.sv
// rtl/fib_seq_ctrl_pkg.sv - sequencer state encodings, terminal term and 7-seg digit constants
package fib_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } fib_state_t;

  // Last Fibonacci term that fits in 8 bits (index 13).
  localparam logic [7:0] FIB_TERM_VALUE = 8'd233;
  localparam int         FIB_LAST_INDEX = 13;

  // Segment order {g,f,e,d,c,b,a}, active high; shared with the display decoder.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fib_tick_gen.sv
// rtl/fib_tick_gen.sv - advance-tick prescaler; FIB_CTRL_SPEED_EN adds speed_sel divisor shift
module fib_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
`ifdef FIB_CTRL_SPEED_EN
  input  logic [1:0] speed_sel,
`endif
  output logic       tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;
  logic [31:0]   terminal;

`ifdef FIB_CTRL_SPEED_EN
  logic [31:0] div_sel;

  // >= compare: a smaller divisor chosen mid-count fires on the next cycle.
  always_comb begin
    div_sel  = 32'(TICK_DIV) >> speed_sel;
    terminal = (div_sel > 32'd1) ? div_sel - 32'd1 : 32'd0;
  end
`else
  assign terminal = 32'(TICK_DIV - 1);
`endif

  assign tick = en && (32'(count) >= terminal);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      if (tick) count <= '0;
      else      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fib_seq_ctrl.sv
// rtl/fib_seq_ctrl.sv - run/pause/step sequencer for the Fibonacci datapath
// FIB_CTRL_SPEED_EN adds the speed_sel input that shortens the advance period.
module fib_seq_ctrl
  import fib_seq_ctrl_pkg::*;
#(
  parameter int         TICK_DIV   = 25000000,
  parameter logic [7:0] TERM_VALUE = FIB_TERM_VALUE,
  parameter int         CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             auto_wrap,
  input  logic [7:0]       fib_value,
`ifdef FIB_CTRL_SPEED_EN
  input  logic [1:0]       speed_sel,
`endif
  output logic             adv,
  output logic             clr,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  fib_state_t       state, state_nxt;
  logic             adv_nxt, clr_nxt;
  logic [CNT_W-1:0] count_nxt, count_inc;
  logic             tick, tick_en, tick_clr, at_term;

  assign at_term   = (fib_value == TERM_VALUE);
  assign count_inc = (&step_count) ? step_count : step_count + CNT_W'(1);
  assign tick_en   = (state == ST_RUN);
  assign running   = (state == ST_RUN);
  assign halted    = (state == ST_HALT);

  fib_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (tick_en),
    .clr       (tick_clr),
`ifdef FIB_CTRL_SPEED_EN
    .speed_sel (speed_sel),
`endif
    .tick      (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      adv        <= 1'b0;
      clr        <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_nxt;
      adv        <= adv_nxt;
      clr        <= clr_nxt;
      step_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adv_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    count_nxt = step_count;
    tick_clr  = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt = ST_RUN;
          clr_nxt   = 1'b1;
          count_nxt = '0;
          tick_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        if (start) begin
          clr_nxt   = 1'b1;
          count_nxt = '0;
          tick_clr  = 1'b1;
        end else if (pause) begin
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          if (!at_term) begin
            adv_nxt   = 1'b1;
            count_nxt = count_inc;
          end else if (auto_wrap) begin
            clr_nxt   = 1'b1;
            count_nxt = '0;
          end else begin
            state_nxt = ST_HALT;
          end
        end
      end
      ST_PAUSE: begin
        // Resume keeps the current term; only the prescaler restarts.
        if (start) begin
          state_nxt = ST_RUN;
          tick_clr  = 1'b1;
        end else if (!pause && step && !adv && !at_term) begin
          adv_nxt   = 1'b1;
          count_nxt = count_inc;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb/tb_fib_seq_ctrl.sv - scoreboard bench for fib_seq_ctrl with a behavioural datapath model
module tb_fib_seq_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic       auto_wrap = 1'b0;
  logic [7:0] fib_value;
  logic       adv, clr, running, halted;
  logic [3:0] step_count;
`ifdef FIB_CTRL_SPEED_EN
  logic [1:0] speed_sel = 2'd0;
`endif

  logic [7:0] prev, cur;

  typedef struct {
    logic       is_clr;
    logic [3:0] sc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] fib_tab [0:13] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                                 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
  int         n_chk = 0;
  int         n_pass = 0;
  logic       fib_pend = 1'b0;
  logic [7:0] fib_exp = 8'd0;

  always #5 clk = ~clk;

  fib_seq_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .TERM_VALUE (8'd233),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .step       (step),
    .auto_wrap  (auto_wrap),
    .fib_value  (fib_value),
`ifdef FIB_CTRL_SPEED_EN
    .speed_sel  (speed_sel),
`endif
    .adv        (adv),
    .clr        (clr),
    .running    (running),
    .halted     (halted),
    .step_count (step_count)
  );

  // Datapath: prev/cur registers driven by adv/clr.
  always @(posedge clk) begin
    if (reset || clr) begin
      prev <= 8'd0;
      cur  <= 8'd1;
    end else if (adv) begin
      prev <= cur;
      cur  <= prev + cur;
    end
  end
  assign fib_value = prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push_exp(input logic is_clr, input logic [3:0] sc);
    exp_t e;
    e.is_clr = is_clr;
    e.sc     = sc;
    sb_q.push_back(e);
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic press_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_pulse(input logic want_clr, input logic [3:0] sc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (want_clr ? clr : adv) && (step_count == sc);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // Scoreboard: every adv/clr pulse is matched against the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (fib_pend) begin
      chk("sb_fib_value", 32'(fib_value), 32'(fib_exp));
      fib_pend = 1'b0;
    end
    if (!reset && (adv || clr)) begin
      chk("adv_clr_exclusive", 32'(adv & clr), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'({adv, clr}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pulse_kind", 32'(clr), 32'(e.is_clr));
        chk("sb_step_count", 32'(step_count), 32'(e.sc));
        fib_exp  = e.is_clr ? 8'd0 : fib_tab[e.sc];
        fib_pend = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_adv", 32'(adv), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    reset = 1'b0;

    // Free run to the last term with auto_wrap off.
    push_exp(1'b1, 4'd0);
    for (int k = 1; k <= 13; k++) push_exp(1'b0, 4'(k));
    press_start();
    chk("start_clr", 32'(clr), 32'd1);
    chk("start_running", 32'(running), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      repeat (TICK_DIV - 1) begin
        @(negedge clk);
        chk("adv_gap", 32'(adv), 32'd0);
      end
      @(negedge clk);
      chk("adv_tick", 32'(adv), 32'd1);
    end
    wait_pulse(1'b0, 4'd13, "reach_233");
    repeat (TICK_DIV) @(negedge clk);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_not_running", 32'(running), 32'd0);
    chk("halt_fib", 32'(fib_value), 32'd233);
    chk("halt_step_count", 32'(step_count), 32'd13);
    press_step();
    press_pause();
    chk("halt_ignores_step", 32'(halted), 32'd1);

    // Restart from HALT with auto_wrap on; the terminal tick reloads.
    auto_wrap = 1'b1;
    push_exp(1'b1, 4'd0);
    for (int k = 1; k <= 13; k++) push_exp(1'b0, 4'(k));
    push_exp(1'b1, 4'd0);
    for (int k = 1; k <= 5; k++) push_exp(1'b0, 4'(k));
    press_start();
    chk("restart_clr", 32'(clr), 32'd1);
    wait_pulse(1'b1, 4'd0, "wrap_clr");
    chk("wrap_running", 32'(running), 32'd1);
    chk("wrap_no_adv", 32'(adv), 32'd0);
    wait_pulse(1'b0, 4'd5, "reach_5");

    // Pause lands on the tick cycle: that tick is dropped.
    repeat (TICK_DIV - 1) @(negedge clk);
    press_pause();
    chk("pause_drops_tick", 32'(adv), 32'd0);
    chk("pause_not_running", 32'(running), 32'd0);
    repeat (2 * TICK_DIV) @(negedge clk);
    chk("pause_frozen_count", 32'(step_count), 32'd5);
    chk("pause_fib", 32'(fib_value), 32'd5);

    // Single steps, one of them while adv is still high.
    push_exp(1'b0, 4'd6);
    press_step();
    chk("step_adv", 32'(adv), 32'd1);
    press_step();
    chk("step_guard", 32'(adv), 32'd0);
    push_exp(1'b0, 4'd7);
    press_step();
    @(negedge clk);
    push_exp(1'b0, 4'd8);
    press_step();
    @(negedge clk);
    chk("steps_fib", 32'(fib_value), 32'd21);
    chk("steps_count", 32'(step_count), 32'd8);

    // start beats pause and step: resume without reload.
    push_exp(1'b0, 4'd9);
    start = 1'b1; pause = 1'b1; step = 1'b1;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; step = 1'b0;
    chk("resume_running", 32'(running), 32'd1);
    chk("resume_no_clr", 32'(clr), 32'd0);
    chk("resume_no_adv", 32'(adv), 32'd0);
    wait_pulse(1'b0, 4'd9, "resume_adv");

    // Reset on the cycle a tick is due.
    repeat (TICK_DIV - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_adv", 32'(adv), 32'd0);
    chk("midrst_clr", 32'(clr), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_step_count", 32'(step_count), 32'd0);
    reset = 1'b0;
    auto_wrap = 1'b0;

`ifdef FIB_CTRL_SPEED_EN
    speed_sel = 2'd2;
    push_exp(1'b1, 4'd0);
    for (int k = 1; k <= 3; k++) push_exp(1'b0, 4'(k));
    press_start();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("fast_adv", 32'(adv), 32'd1);
    end
    press_pause();
    chk("fast_pause", 32'(adv), 32'd0);
    speed_sel = 2'd0;
    push_exp(1'b0, 4'd4);
    press_start();
    chk("speed_resume_no_clr", 32'(clr), 32'd0);
    @(negedge clk);
    chk("speed_slow_gap", 32'(adv), 32'd0);
    speed_sel = 2'd1;
    @(negedge clk);
    chk("speed_switch_tick", 32'(adv), 32'd1);
    press_pause();
    chk("speed_paused", 32'(running), 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
